// File: rtl/imem_loader.sv
// imem_loader: streams bytes from an upstream byte channel into instruction
// memory while holding the CPU in reset. Bytes are packed little-endian into
// 32-bit words. Each complete word gets a one-cycle write strobe at the next
// word-aligned address. The CPU is released once the requested number of
// words has been written.
//
// Optional build macro IMEM_LOADER_CHECKSUM_EN: after the last word, one
// trailer byte is accepted and compared to the 8-bit sum of all data bytes.
// A match releases the CPU. A mismatch enters an error state, which keeps the
// CPU in reset until a new start or reset.
//
// Parameters:
//   DEPTH_WORDS - instruction-memory capacity in 32-bit words
//   LEN_W       - width of load_len, wide enough to hold DEPTH_WORDS
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   start      - one-cycle load request (honoured in IDLE/DONE/ERR)
//   load_len   - words to load, clamped to DEPTH_WORDS, latched on start
//   byte_valid - upstream byte strobe
//   byte_data  - upstream byte payload
//   byte_ready - loader accepts byte_data this cycle
//   imem_we    - instruction-memory write strobe
//   imem_addr  - word-aligned byte address of the write
//   imem_wdata - assembled instruction word
//   cpu_reset  - holds the CPU in reset while high
//   busy       - a load is in progress
//   done       - load complete, CPU released
//   error      - checksum mismatch (tied low without the checksum build)
module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int LEN_W       = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] load_len,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE, ERR} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] word_idx;
    logic [LEN_W-1:0] word_nxt;
    logic [LEN_W-1:0] len_clamped;
    logic [1:0]       byte_idx;
    logic [23:0]      pack;
    logic             accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        word_nxt    = word_idx + LEN_W'(1);
        len_clamped = (load_len > LEN_W'(DEPTH_WORDS)) ? LEN_W'(DEPTH_WORDS) : load_len;
        byte_ready  = (state == LOAD) || (state == CHECK);
        accept      = byte_valid && byte_ready;
        imem_we     = (state == WRITE);
        busy        = (state == LOAD) || (state == WRITE) || (state == CHECK);
        done        = (state == DONE);
        cpu_reset   = (state != DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        error       = (state == ERR);
`else
        error       = 1'b0;
`endif
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = (load_len == '0) ? DONE : LOAD;
            end
            LOAD: begin
                if (accept && byte_idx == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_nxt = (word_nxt == len) ? CHECK : LOAD;
`else
                state_nxt = (word_nxt == len) ? DONE : LOAD;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) state_nxt = (byte_data == csum) ? DONE : ERR;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // The write address/data registers are loaded together with the 4th byte.
    // They are valid during WRITE and keep their values afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len        <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            pack       <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        len      <= len_clamped;
                        word_idx <= '0;
                        byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum + byte_data;
`endif
                        case (byte_idx)
                            2'd0: pack[7:0]   <= byte_data;
                            2'd1: pack[15:8]  <= byte_data;
                            2'd2: pack[23:16] <= byte_data;
                            default: begin
                                imem_wdata <= {byte_data, pack};
                                imem_addr  <= 32'({word_idx, 2'b00});
                            end
                        endcase
                    end
                end
                WRITE: word_idx <= word_nxt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. A byte-level model turns
// each stream into its expected word writes. A single negedge compare process
// checks every write and the hold behaviour in between. Directed checks pin
// the model with hand-computed literals.
module tb_imem_loader;
    localparam int DEPTH = 256;
    localparam int LW    = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] load_len;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready, imem_we, cpu_reset, busy, done, error;
    logic [31:0]   imem_addr, imem_wdata;

    imem_loader #(.DEPTH_WORDS(DEPTH), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          st_cyc = 0;
    logic [31:0] exp_a[$], exp_d[$];
    logic [31:0] wlog_a[$], wlog_d[$];
    int          wlog_c[$];
    logic [31:0] last_a = '0, last_d = '0;
    logic [7:0]  bq[$];
    bit          pq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int nwords(input int len, input int nbytes);
        int n = (len > DEPTH) ? DEPTH : len;
        return (nbytes / 4 < n) ? nbytes / 4 : n;
    endfunction

    // Model: word k = bytes 4k..4k+3, little-endian, written at byte address 4k.
    task automatic expect_words(input logic [7:0] b[$], input int len);
        for (int k = 0; k < nwords(len, b.size()); k++) begin
            exp_a.push_back(32'(4 * k));
            exp_d.push_back({b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]});
        end
    endtask

    // Compare process: every write must match the next expected write.
    // Between writes, the address and data must hold the last written values.
    always @(negedge clk) begin
        if (reset) begin
            exp_a.delete();
            exp_d.delete();
            last_a = '0;
            last_d = '0;
        end else begin
            if (imem_we) begin
                wlog_a.push_back(imem_addr);
                wlog_d.push_back(imem_wdata);
                wlog_c.push_back(cyc);
                if (exp_a.size() == 0) chk("unexpected_write", 32'(imem_we), 32'd0);
                else begin
                    last_a = exp_a.pop_front();
                    last_d = exp_d.pop_front();
                    chk("wr_addr", imem_addr, last_a);
                    chk("wr_data", imem_wdata, last_d);
                end
            end else begin
                chk("hold_addr", imem_addr, last_a);
                chk("hold_data", imem_wdata, last_d);
            end
            chk("cpu_reset_vs_done", 32'(cpu_reset), 32'(!done));
`ifndef IMEM_LOADER_CHECKSUM_EN
            chk("error_tied_low", 32'(error), 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        load_len = LW'(len);
        st_cyc   = cyc;
        tick();
        start = 1'b0;
    endtask

    // Present the bytes in b. pat gives byte_valid per cycle (then 1).
    // inj >= 0 pulses start with a different length once, after that many
    // bytes have been accepted.
    task automatic stream(input logic [7:0] b[$], input bit pat[$], input int inj);
        int n = 0;
        int c = 0;
        bit v, injected = 0;
        logic r;
        logic [LW-1:0] keep = load_len;
        while (n < b.size() && c < 4000) begin
            v          = (c < pat.size()) ? pat[c] : 1'b1;
            byte_valid = v;
            byte_data  = v ? b[n] : 8'hEE;
            if (inj >= 0 && n == inj && !injected) begin
                start    = 1'b1;
                load_len = LW'(1);
                injected = 1;
            end
            @(negedge clk);
            r = byte_ready;
            tick();
            start    = 1'b0;
            load_len = keep;
            if (v && r) n++;
            c++;
        end
        byte_valid = 1'b0;
        chk("stream_accepted_bytes", 32'(n), 32'(b.size()));
    endtask

    task automatic run_load(input int len, input logic [7:0] b[$], input bit pat[$], input int inj);
        logic [7:0] d[$];
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] s = '0;
`endif
        d = b;
        expect_words(b, len);
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int i = 0; i < 4 * nwords(len, b.size()); i++) s = s + b[i];
        d.push_back(s);
`endif
        do_start(len);
        stream(d, pat, inj);
    endtask

    task automatic add4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        bq.push_back(a);
        bq.push_back(b);
        bq.push_back(c);
        bq.push_back(d);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        logic [6:0] pv;
        reset = 1'b1; start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
        tick(); tick();
        chk("rst_we", 32'(imem_we), 0);       chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);      chk("rst_ready", 32'(byte_ready), 0);
        chk("rst_busy", 32'(busy), 0);        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);      chk("rst_cpu_reset", 32'(cpu_reset), 1);
        reset = 1'b0;
        tick();

        // Two-word load, back-to-back bytes
        base = wlog_a.size();
        bq.delete(); pq.delete();
        add4(8'h13, 8'h00, 8'h00, 8'h00); add4(8'h93, 8'h00, 8'h10, 8'h00);
        run_load(2, bq, pq, -1);
        tick(); tick();
        chk("t1_nwrites", 32'(wlog_a.size() - base), 2);
        chk("t1_addr0", qat(wlog_a, base), 32'h0);
        chk("t1_data0", qat(wlog_d, base), 32'h0000_0013);
        chk("t1_addr1", qat(wlog_a, base + 1), 32'h4);
        chk("t1_data1", qat(wlog_d, base + 1), 32'h0010_0093);
        if (wlog_c.size() >= base + 2) begin
            chk("t1_cycle0", 32'(wlog_c[base] - st_cyc), 5);
            chk("t1_cycle1", 32'(wlog_c[base + 1] - st_cyc), 10);
        end else chk("t1_write_cycles_logged", 32'(wlog_c.size() - base), 2);
        chk("t1_done", 32'(done), 1);
        chk("t1_cpu_reset", 32'(cpu_reset), 0);

        // Stalled stream, restarted from DONE
        base = wlog_a.size();
        bq.delete(); pq.delete();
        add4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        pv = 7'b1001101;
        for (int i = 0; i < 7; i++) pq.push_back(pv[6 - i]);
        expect_words(bq, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        bq.push_back(8'h0E);
`endif
        do_start(1);
        chk("t2_restart_cpu_reset", 32'(cpu_reset), 1);
        chk("t2_restart_busy", 32'(busy), 1);
        stream(bq, pq, -1);
        tick();
        chk("t2_nwrites", 32'(wlog_a.size() - base), 1);
        chk("t2_addr", qat(wlog_a, base), 32'h0);
        chk("t2_data", qat(wlog_d, base), 32'hDDCC_BBAA);
        chk("t2_done", 32'(done), 1);

        // Length clamped to memory depth
        base = wlog_a.size();
        bq.delete(); pq.delete();
        for (int i = 0; i < 4 * DEPTH; i++) bq.push_back(8'((i * 37 + 5) & 255));
        run_load(300, bq, pq, -1);
        tick();
        chk("t3_nwrites", 32'(wlog_a.size() - base), 256);
        chk("t3_last_addr", qat(wlog_a, wlog_a.size() - 1), 32'h3FC);
        chk("t3_last_data", qat(wlog_d, wlog_d.size() - 1), 32'hE0BB_9671);
        chk("t3_done", 32'(done), 1);
        byte_valid = 1'b1; byte_data = 8'h55;
        repeat (4) tick();
        chk("t3_no_extra_ready", 32'(byte_ready), 0);
        byte_valid = 1'b0;

        // Empty load
        base = wlog_a.size();
        do_start(0);
        chk("t3_empty_done", 32'(done), 1);
        chk("t3_empty_busy", 32'(busy), 0);
        byte_valid = 1'b1; byte_data = 8'h77;
        repeat (6) tick();
        byte_valid = 1'b0;
        chk("t3_empty_nwrites", 32'(wlog_a.size() - base), 0);

        // Reset in the middle of word two
        reset = 1'b1; tick(); reset = 1'b0; tick();
        base = wlog_a.size();
        bq.delete(); pq.delete();
        add4(8'h01, 8'h23, 8'h45, 8'h67); bq.push_back(8'h89); bq.push_back(8'hAB);
        expect_words(bq, 4);
        do_start(4);
        stream(bq, pq, -1);
        chk("t4_pending", 32'(exp_a.size()), 0);
        reset = 1'b1;
        #1;
        chk("t4_async_cpu_reset", 32'(cpu_reset), 1);
        chk("t4_async_busy", 32'(busy), 0);
        chk("t4_async_we", 32'(imem_we), 0);
        chk("t4_async_addr", imem_addr, 0);
        chk("t4_async_ready", 32'(byte_ready), 0);
        tick();
        reset = 1'b0;
        byte_valid = 1'b1; byte_data = 8'hCD;
        repeat (12) tick();
        byte_valid = 1'b0;
        chk("t4_nwrites", 32'(wlog_a.size() - base), 1);
        chk("t4_data0", qat(wlog_d, base), 32'h6745_2301);
        chk("t4_idle_busy", 32'(busy), 0);
        chk("t4_idle_done", 32'(done), 0);

        // Start pulse during LOAD
        base = wlog_a.size();
        bq.delete(); pq.delete();
        add4(8'h10, 8'h20, 8'h30, 8'h40); add4(8'h50, 8'h60, 8'h70, 8'h80);
        run_load(2, bq, pq, 2);
        tick();
        chk("t5_nwrites", 32'(wlog_a.size() - base), 2);
        chk("t5_data0", qat(wlog_d, base), 32'h4030_2010);
        chk("t5_data1", qat(wlog_d, base + 1), 32'h8070_6050);
        chk("t5_done", 32'(done), 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Trailer checksum: good, bad, then recovery
        bq.delete(); pq.delete();
        add4(8'h01, 8'h02, 8'h03, 8'h04);
        expect_words(bq, 1);
        bq.push_back(8'h0A);
        do_start(1); stream(bq, pq, -1); tick();
        chk("t6_good_done", 32'(done), 1);
        chk("t6_good_error", 32'(error), 0);
        bq[4] = 8'h0B;
        expect_words(bq, 1);
        do_start(1); stream(bq, pq, -1); tick();
        chk("t6_bad_error", 32'(error), 1);
        chk("t6_bad_cpu_reset", 32'(cpu_reset), 1);
        chk("t6_bad_done", 32'(done), 0);
        bq[4] = 8'h0A;
        expect_words(bq, 1);
        do_start(1);
        chk("t6_restart_error", 32'(error), 0);
        stream(bq, pq, -1); tick();
        chk("t6_recover_done", 32'(done), 1);
`endif

        chk("final_pending", 32'(exp_a.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, the instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter LEN_W, default 9, the width of load_len, sized to hold the value DEPTH_WORDS.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle load request, sampled in IDLE, DONE and ERR.
REQ-006 SHALL have port load_len  input  LEN_W  number of words to load, latched when start is accepted.
REQ-007 SHALL have port byte_valid  input  1  upstream byte strobe.
REQ-008 SHALL have port byte_data  input  8  upstream byte payload.
REQ-009 SHALL have port byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port imem_addr  output  32  byte address of the written word, always word-aligned.
REQ-012 SHALL have port imem_wdata  output  32  assembled instruction word.
REQ-013 SHALL have port cpu_reset  output  1  holds the CPU in reset while high.
REQ-014 SHALL have port busy  output  1  high in LOAD, WRITE and CHECK.
REQ-015 SHALL have port done  output  1  high in DONE.
REQ-016 SHALL have port error  output  1  high in ERR.

Function
REQ-017 SHALL implement the states IDLE, LOAD, WRITE, CHECK, DONE and ERR.
REQ-018 Byte transfer SHALL occur only on a rising edge where byte_valid=1 and byte_ready=1; byte_ready=1 only in LOAD and CHECK.
REQ-019 Start accepted in IDLE, DONE or ERR SHALL latch min(load_len, DEPTH_WORDS), clear the byte index, word index and checksum, and go to LOAD, or go to DONE if load_len=0.
REQ-020 Start in LOAD, WRITE or CHECK SHALL be ignored.
REQ-021 In LOAD, bytes SHALL be packed little-endian: the 1st byte goes to [7:0] and the 4th byte to [31:24]; the 4th accepted byte moves the block to WRITE.
REQ-022 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr={word_idx,2'b00} and imem_wdata holding the packed word.
REQ-023 After WRITE, word_idx SHALL increment; if it reaches the latched length, the next state is CHECK (macro defined) or DONE, otherwise LOAD.
REQ-024 Minimum throughput SHALL be 5 cycles per word: 4 accept cycles plus 1 write cycle.
REQ-025 cpu_reset SHALL be 0 only in DONE; re-start from DONE SHALL reassert it in the next cycle.
REQ-026 imem_we SHALL be 0 in all states other than WRITE; a partially assembled word SHALL never be written.
REQ-027 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.
REQ-028 byte_valid outside LOAD/CHECK SHALL have no effect, and no byte SHALL be lost or duplicated on a byte_valid stall.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE, byte/word index 0, checksum 0, imem_we=0, imem_addr=0, imem_wdata=0, byte_ready=0, busy=0, done=0, error=0 and cpu_reset=1.
REQ-030 Reset during LOAD or WRITE SHALL abort the load, and no further imem_we pulse SHALL occur until a new start is accepted.

Configuration
REQ-031 With macro IMEM_LOADER_CHECKSUM_EN defined, CHECK SHALL accept one trailer byte and compare it to the 8-bit sum (mod 256) of all data bytes; on a match it goes to DONE, on a mismatch to ERR.
REQ-032 ERR SHALL keep cpu_reset=1 and error=1 until reset or an accepted start.
REQ-033 Without IMEM_LOADER_CHECKSUM_EN, CHECK and ERR SHALL be unreachable, no trailer byte SHALL be consumed, and error SHALL be tied to 0.

Verification
REQ-034 Load: load_len=2, bytes 13 00 00 00 93 00 10 00 streamed back-to-back. Required: imem_we at cycles 5 and 10, writes (0x0,0x00000013) and (0x4,0x00100093), then done=1 and cpu_reset=0.
REQ-035 Stall: byte_valid toggled 1,0,0,1,1,0,1 for one word AA BB CC DD. Required: exactly one write of 0xDDCCBBAA to address 0x0.
REQ-036 Clamp and empty load: load_len=300 writes 256 words, the last to 0x3FC; load_len=0 goes directly to DONE with no writes.
REQ-037 Reset mid-load: reset asserted after 6 bytes with load_len=4. Required: exactly one write observed, cpu_reset=1, state IDLE, no later imem_we.
REQ-038 Checksum (macro defined): load_len=1, bytes 01 02 03 04. Trailer 0x0A gives done=1; trailer 0x0B gives error=1, cpu_reset=1; a new start clears error.
REQ-039 Start during LOAD: a start pulse plus a new load_len mid-word SHALL leave the latched length and the byte stream unaffected.
